// File: rtl/load_unit_pkg.sv
// ----------------------------------------------------------------------------
// load_unit_pkg
// Shared CPU definitions used by the load unit:
//   - RV32 load funct3 encodings
//   - load unit FSM state enum
//   - fault_cause encodings
//   - check_load(): classifies a load as legal, misaligned or illegal
// ----------------------------------------------------------------------------
package load_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_FAULT = 3'd4
    } load_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_MISALIGNED = 2'd1,
        CAUSE_ILLEGAL    = 2'd2,
        CAUSE_TIMEOUT    = 2'd3
    } fault_cause_e;

    // An unknown funct3 is reported as illegal regardless of the address,
    // so the illegal check naturally wins over the alignment check.
    function automatic fault_cause_e check_load(input logic [2:0] f3,
                                                input logic [1:0] lo);
        case (f3)
            F3_LB, F3_LBU: check_load = CAUSE_NONE;
            F3_LH, F3_LHU: check_load = lo[0] ? CAUSE_MISALIGNED : CAUSE_NONE;
            F3_LW:         check_load = (lo != 2'b00) ? CAUSE_MISALIGNED : CAUSE_NONE;
            default:       check_load = CAUSE_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// ----------------------------------------------------------------------------
// load_extract
// Combinational byte/half lane select with sign or zero extension.
//   funct3_i   : load type (lb/lh/lw/lbu/lhu)
//   byte_off_i : addr[1:0] of the load
//   word_i     : aligned 32-bit memory word
//   data_o     : extended value for the register file
// ----------------------------------------------------------------------------
module load_extract
    import load_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (byte_off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// ----------------------------------------------------------------------------
// load_unit
// Multi-cycle load FSM: IDLE -> REQ -> WAIT -> WB, or -> FAULT on an illegal,
// misaligned or timed-out load. All outputs are registered.
//   clock, reset          : clock, asynchronous active-high reset
//   start/funct3/addr/rd  : load issue from execute (ignored while busy)
//   busy                  : pipeline stall, high whenever not IDLE
//   mem_req_*             : word-aligned memory request (valid/ready)
//   mem_resp_*            : memory response, accepted only in WAIT
//   reg_write/write_reg/mem_load_data/load_enable : register write-back
//   fault/fault_cause     : one-cycle fault pulse with cause code
// ----------------------------------------------------------------------------
module load_unit
    import load_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] mem_load_data,
    output logic        load_enable,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    load_state_e      state_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] cnt_q;

    logic             busy_q;
    logic             mem_req_valid_q;
    logic [31:0]      mem_req_addr_q;
    logic             reg_write_q;
    logic [4:0]       write_reg_q;
    logic [31:0]      mem_load_data_q;
    logic             load_enable_q;
    logic             fault_q;
    logic [1:0]       fault_cause_q;

    fault_cause_e     start_cause_d;
    logic [31:0]      extracted_d;

    assign start_cause_d = check_load(funct3, addr[1:0]);

    // Extraction uses the latched load type and byte offset, not the live inputs.
    load_extract u_extract (
        .funct3_i   (funct3_q),
        .byte_off_i (off_q),
        .word_i     (mem_resp_data),
        .data_o     (extracted_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            funct3_q        <= 3'd0;
            off_q           <= 2'd0;
            rd_q            <= 5'd0;
            cnt_q           <= '0;
            busy_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= 32'd0;
            reg_write_q     <= 1'b0;
            write_reg_q     <= 5'd0;
            mem_load_data_q <= 32'd0;
            load_enable_q   <= 1'b0;
            fault_q         <= 1'b0;
            fault_cause_q   <= 2'd0;
        end else begin
            // Write-back and fault outputs are single-cycle pulses.
            reg_write_q     <= 1'b0;
            write_reg_q     <= 5'd0;
            mem_load_data_q <= 32'd0;
            load_enable_q   <= 1'b0;
            fault_q         <= 1'b0;
            fault_cause_q   <= 2'd0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        funct3_q <= funct3;
                        off_q    <= addr[1:0];
                        rd_q     <= rd;
                        busy_q   <= 1'b1;
                        if (start_cause_d == CAUSE_NONE) begin
                            state_q         <= S_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {addr[31:2], 2'b00};
                        end else begin
                            state_q       <= S_FAULT;
                            fault_q       <= 1'b1;
                            fault_cause_q <= start_cause_d;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        state_q         <= S_WAIT;
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
                    end
                end
                S_WAIT: begin
                    // A response in the final allowed cycle still wins over timeout.
                    if (mem_resp_valid) begin
                        state_q         <= S_WB;
                        load_enable_q   <= 1'b1;
                        reg_write_q     <= (rd_q != 5'd0);
                        write_reg_q     <= rd_q;
                        mem_load_data_q <= extracted_d;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q       <= S_FAULT;
                        fault_q       <= 1'b1;
                        fault_cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB, S_FAULT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q         <= S_IDLE;
                    busy_q          <= 1'b0;
                    mem_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign reg_write     = reg_write_q;
    assign write_reg     = write_reg_q;
    assign mem_load_data = mem_load_data_q;
    assign load_enable   = load_enable_q;
    assign fault         = fault_q;
    assign fault_cause   = fault_cause_q;

endmodule

// File: tb/tb_load_unit.sv
// ----------------------------------------------------------------------------
// tb_load_unit
// Self-checking bench for load_unit: a table of directed loads, timeout and
// reset-in-flight sequences, and randomized loads checked against a
// behavioural model of the load rules.
// ----------------------------------------------------------------------------
module tb_load_unit;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        busy;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'd0;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] mem_load_data;
    logic        load_enable;
    logic        fault;
    logic [1:0]  fault_cause;

    int total = 0;
    int bad   = 0;

    load_unit #(.TIMEOUT(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .funct3         (funct3),
        .addr           (addr),
        .rd             (rd),
        .busy           (busy),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .reg_write      (reg_write),
        .write_reg      (write_reg),
        .mem_load_data  (mem_load_data),
        .load_enable    (load_enable),
        .fault          (fault),
        .fault_cause    (fault_cause)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte/half picked by shifting the word, extension by arithmetic.
    function automatic void ref_load(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] w,
                                     output logic [1:0] cause, output logic [31:0] data);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * int'(a % 4))) & 32'hFF;
        h = (w >> (16 * int'((a % 4) / 2))) & 32'hFFFF;
        cause = 2'd0;
        data  = 32'd0;
        case (int'(f3))
            0: data = (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
            4: data = 32'(b);
            1: if (a % 2 != 0) cause = 2'd1; else data = (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
            5: if (a % 2 != 0) cause = 2'd1; else data = 32'(h);
            2: if (a % 4 != 0) cause = 2'd1; else data = w;
            default: cause = 2'd2;
        endcase
    endfunction

    // Issues one load at a negedge (cycle N) and checks the whole transaction.
    // rdy: cycles ready is held low; rsp: WAIT cycles before the response.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                           input logic [31:0] w, input int rdy, input int rsp,
                           input logic [1:0] exp_cause, input logic [31:0] exp_data);
        logic [31:0] exp_addr;
        exp_addr = {a[31:2], 2'b00};
        start = 1'b1; funct3 = f3; addr = a; rd = r;
        @(negedge clock);
        start = 1'b0; funct3 = 3'($urandom); addr = $urandom; rd = 5'($urandom);
        if (exp_cause != 2'd0) begin
            chk("fault_pulse", {31'd0, fault}, 32'd1);
            chk("fault_cause", {30'd0, fault_cause}, {30'd0, exp_cause});
            chk("fault_no_req", {31'd0, mem_req_valid}, 32'd0);
            chk("fault_no_wb", {31'd0, load_enable}, 32'd0);
            @(negedge clock);
            chk("fault_busy_clear", {31'd0, busy}, 32'd0);
            chk("fault_one_cycle", {31'd0, fault}, 32'd0);
            return;
        end
        chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("req_addr", mem_req_addr, exp_addr);
        chk("busy_req", {31'd0, busy}, 32'd1);
        // Stalled request; stray responses and new starts must be ignored.
        for (int i = 0; i < rdy; i++) begin
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b1; mem_resp_data = $urandom;
            start = 1'b1; addr = $urandom; funct3 = 3'd2;
            @(negedge clock);
            chk("req_valid_held", {31'd0, mem_req_valid}, 32'd1);
            chk("req_addr_stable", mem_req_addr, exp_addr);
        end
        start = 1'b0;
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_data = $urandom;  // same-cycle response is discarded
        @(negedge clock);
        mem_req_ready = 1'b0;
        chk("req_dropped", {31'd0, mem_req_valid}, 32'd0);
        chk("no_early_wb", {31'd0, load_enable}, 32'd0);
        for (int i = 0; i < rsp; i++) begin
            mem_resp_valid = 1'b0;
            start = 1'b1; addr = $urandom;
            @(negedge clock);
            chk("wait_no_wb", {31'd0, load_enable | fault}, 32'd0);
        end
        start = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = w;
        @(negedge clock);
        mem_resp_valid = 1'b0; mem_resp_data = $urandom;
        chk("wb_load_enable", {31'd0, load_enable}, 32'd1);
        chk("wb_reg_write", {31'd0, reg_write}, {31'd0, r != 5'd0});
        chk("wb_write_reg", {27'd0, write_reg}, {27'd0, r});
        chk("wb_data", mem_load_data, exp_data);
        @(negedge clock);
        chk("wb_one_cycle", {31'd0, load_enable | reg_write}, 32'd0);
        chk("wb_busy_clear", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [4:0]  r;
        logic [31:0] w;
        int          rdy;
        int          rsp;
        logic [1:0]  cause;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{3'd2, 32'h100, 5'd5,  32'hDEADBEEF, 0, 0, 2'd0, 32'hDEADBEEF};
        vecs[1]  = '{3'd0, 32'h103, 5'd6,  32'h80FF1234, 0, 0, 2'd0, 32'hFFFFFF80};
        vecs[2]  = '{3'd4, 32'h103, 5'd7,  32'h80FF1234, 1, 1, 2'd0, 32'h00000080};
        vecs[3]  = '{3'd1, 32'h101, 5'd8,  32'h80FF1234, 0, 0, 2'd1, 32'h0};
        vecs[4]  = '{3'd2, 32'h200, 5'd0,  32'h12345678, 5, 0, 2'd0, 32'h12345678};
        vecs[5]  = '{3'd1, 32'h102, 5'd9,  32'hF00D1234, 0, 2, 2'd0, 32'hFFFFF00D};
        vecs[6]  = '{3'd5, 32'h102, 5'd10, 32'hF00D1234, 2, 0, 2'd0, 32'h0000F00D};
        vecs[7]  = '{3'd3, 32'h100, 5'd11, 32'h0,        0, 0, 2'd2, 32'h0};
        vecs[8]  = '{3'd7, 32'h103, 5'd12, 32'h0,        0, 0, 2'd2, 32'h0};
        vecs[9]  = '{3'd2, 32'h102, 5'd13, 32'h0,        0, 0, 2'd1, 32'h0};
        vecs[10] = '{3'd0, 32'h101, 5'd31, 32'h00007F00, 0, TO - 1, 2'd0, 32'h0000007F};
        vecs[11] = '{3'd1, 32'h100, 5'd1,  32'h00008001, 1, 0, 2'd0, 32'hFFFF8001};

        // Reset state
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outputs", {29'd0, mem_req_valid, reg_write, load_enable}, 32'd0);
        chk("rst_fault", {29'd0, fault, fault_cause}, 32'd0);
        chk("rst_data", mem_req_addr | mem_load_data | {27'd0, write_reg}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 12; i++)
            do_load(vecs[i].f3, vecs[i].a, vecs[i].r, vecs[i].w,
                    vecs[i].rdy, vecs[i].rsp, vecs[i].cause, vecs[i].data);

        // Timeout: TO WAIT cycles without response, then cause 3.
        start = 1'b1; funct3 = 3'd2; addr = 32'h300; rd = 5'd3;
        @(negedge clock);
        start = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("to_waiting", {30'd0, busy, fault}, 32'd2);
            @(negedge clock);
        end
        chk("to_fault", {31'd0, fault}, 32'd1);
        chk("to_cause", {30'd0, fault_cause}, 32'd3);
        chk("to_no_wb", {31'd0, load_enable}, 32'd0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFEF00D;  // late response
        @(negedge clock);
        chk("to_busy_clear", {31'd0, busy}, 32'd0);
        @(negedge clock);
        mem_resp_valid = 1'b0;
        chk("to_late_resp_ignored", {31'd0, load_enable | reg_write}, 32'd0);

        // Reset while in WAIT, then a late response.
        start = 1'b1; funct3 = 3'd2; addr = 32'h400; rd = 5'd4;
        @(negedge clock);
        start = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h11111111;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        chk("rst_no_wb", {30'd0, reg_write, load_enable}, 32'd0);
        chk("rst_idle", {31'd0, busy}, 32'd0);
        @(negedge clock);
        do_load(3'd2, 32'h500, 5'd2, 32'h0BADF00D, 0, 0, 2'd0, 32'h0BADF00D);

        // Randomized loads against the model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] w;
            logic [1:0]  c;
            logic [31:0] d;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            w  = $urandom;
            ref_load(f3, a, w, c, d);
            do_load(f3, a, 5'($urandom), w, $urandom_range(0, 3),
                    $urandom_range(0, TO - 1), c, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
